retire_pair_buffer: RTL
=======================

Name: retire_pair_buffer

Overview:
- Sits between the two lockstepped ibex cores' RVFI retire outputs and the contract checker.
- Buffers each core's retirement records in a per-core FIFO.
- Emits them strictly in pairs (i-th retirement of core 1 with i-th retirement of core 2), so the checker can compare them without clock-gating the cores.
- Provides backpressure, overflow detection and a one-sided-retirement timeout that flags desynchronised runs.

Parameters:
- REC_W, 160, width of one packed retirement record (insn, rd addr/wdata, mem addr/data, new pc; packing decided by the instantiating top).
- DEPTH, 8, entries per core FIFO; power of two, >= 4.
- SLACK, 2, stall asserted when occupancy >= DEPTH-SLACK.
- TIMEOUT, 64, cycles of one-sided occupancy before desync is flagged; >= 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- retire_1_i  in  1  core 1 retires a record this cycle.
- rec_1_i  in  REC_W  core 1 record, valid when retire_1_i.
- retire_2_i  in  1  core 2 retires a record this cycle.
- rec_2_i  in  REC_W  core 2 record, valid when retire_2_i.
- stall_1_o  out  1  request that core 1 stop fetching (drives its fetch enable low).
- stall_2_o  out  1  same for core 2.
- pair_valid_o  out  1  pair output register holds a valid pair.
- pair_ready_i  in  1  checker accepts the pair.
- pair_rec_1_o  out  REC_W  core 1 record of the pair.
- pair_rec_2_o  out  REC_W  core 2 record of the pair.
- pair_count_o  out  32  number of pairs handed over (handshakes).
- overflow_o  out  1  sticky: a record was dropped.
- desync_o  out  1  sticky: one-sided timeout expired.

Behaviour:
- Reset (rst_i high at edge): both FIFOs empty, pointers 0, pair_valid_o=0, pair_rec_*_o=0, pair_count_o=0, overflow_o=0, desync_o=0, timeout counter 0. Outputs stall_1_o and stall_2_o evaluate to 0 (empty FIFOs).
- Reset mid-operation discards all buffered records and the pending output pair. There is no handshake on the reset cycle.
- FIFO k push:
  - Occurs when retire_k_i=1 and (count_k < DEPTH or FIFO k pops in the same cycle).
  - Otherwise the record is dropped and overflow_o is set at that edge. overflow_o stays set until reset.
- Counts and pointers: count_k is a 0..DEPTH counter; pointers wrap modulo DEPTH.
- Pair load:
  - Condition: count_1>0, count_2>0, and (pair_valid_o=0 or pair_ready_i=1).
  - Action: both FIFO heads are popped in the same cycle and written to pair_rec_*_o; pair_valid_o=1 at that edge.
- Handshake:
  - A handshake is a cycle with pair_valid_o && pair_ready_i. It increments pair_count_o by 1, wrapping 2^32-1 -> 0.
  - If no load occurs in a handshake cycle, pair_valid_o clears at the edge.
  - pair_rec_*_o hold stable while pair_valid_o && !pair_ready_i.
- Latency:
  - Simultaneous retirements into empty FIFOs with pair_ready_i=1: a retire at edge t makes pair_valid_o high in the cycle after edge t+1 (2 cycles).
  - Sustained throughput: 1 pair/cycle.
- Ordering: strict FIFO per core; a pair is always the same-index retirement of both cores.
- Push and pop on the same FIFO in the same cycle: both happen; count unchanged.
- stall_k_o = (count_k >= DEPTH-SLACK). It is combinational from registered count and carries no ready dependency.
- Timeout counter:
  - Increments each cycle where exactly one FIFO is non-empty.
  - Clears to 0 on any other cycle.
  - On reaching TIMEOUT, desync_o is set at that edge and the counter saturates. desync_o stays set until reset.
- The block never modifies record content. Zero-width packing fields are the caller's concern.

Test Plan:
- Lockstep: retire_1_i=retire_2_i=1 for 5 cycles with recs 1..5 / 101..105, pair_ready_i=1 -> pairs (1,101)..(5,105) in order, first pair_valid_o 2 cycles after the first retire, pair_count_o=5.
- Skew: core 1 retires recs A,B,C at cycles 0-2; core 2 retires X,Y,Z at cycles 10-12 -> pairs (A,X),(B,Y),(C,Z); no pairs before cycle 12; desync_o stays 0 (one-sided for 10 < 64 cycles).
- Backpressure: DEPTH=8, SLACK=2, pair_ready_i=0, both cores retire 7 records -> stall_k_o=1 once count reaches 6; the pair register holds rec 0 with outputs stable; FIFOs hold 6 each; overflow_o=0.
- Overflow: keep pair_ready_i=0 and push 10 records into core 1 only -> 8 stored, overflow_o=1 after the 9th push. Then push 1 each to core 2 -> pair (rec0_1, rec0_2) appears.
- Timeout: TIMEOUT=4, one core 1 retire, core 2 idle -> desync_o=1 exactly 4 cycles after the record becomes visible in FIFO 1. A later core 2 retire still yields the pair; desync_o stays 1.
- Reset mid-run: rst_i=1 for 1 cycle with 3 records buffered in each FIFO and pair_valid_o=1 -> next cycle all outputs 0, pair_count_o=0. New retirements pair from fresh indices.

Source files
------------

// File: rtl/retire_pair_buffer.sv
// Buffers lockstepped core retirement records per core and emits
// them as same-index pairs with backpressure and desync detection.
module retire_pair_buffer #(
   parameter int REC_W   = 160,
   parameter int DEPTH   = 8,
   parameter int SLACK   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             retire_1_i,
   input  logic [REC_W-1:0] rec_1_i,
   input  logic             retire_2_i,
   input  logic [REC_W-1:0] rec_2_i,
   output logic             stall_1_o,
   output logic             stall_2_o,
   output logic             pair_valid_o,
   input  logic             pair_ready_i,
   output logic [REC_W-1:0] pair_rec_1_o,
   output logic [REC_W-1:0] pair_rec_2_o,
   output logic [31:0]      pair_count_o,
   output logic             overflow_o,
   output logic             desync_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [REC_W-1:0] r_mem_1 [DEPTH];
   logic [REC_W-1:0] r_mem_2 [DEPTH];
   logic [AW-1:0]    r_wp_1, r_rp_1, r_wp_2, r_rp_2;
   logic [CW-1:0]    r_cnt_1, r_cnt_2;
   logic             r_pv;
   logic [REC_W-1:0] r_prec_1, r_prec_2;
   logic [31:0]      r_pcnt;
   logic             r_ovf;
   logic [TW-1:0]    r_to;
   logic             r_desync;

   logic w_load;
   logic w_push_1, w_push_2;
   logic w_hs;
   logic w_one_sided;

   assign w_load = (r_cnt_1 != '0) && (r_cnt_2 != '0)
                && (!r_pv || pair_ready_i);
   assign w_push_1 = retire_1_i && ((r_cnt_1 < CW'(DEPTH)) || w_load);
   assign w_push_2 = retire_2_i && ((r_cnt_2 < CW'(DEPTH)) || w_load);
   assign w_hs = r_pv && pair_ready_i;
   assign w_one_sided = (r_cnt_1 != '0) != (r_cnt_2 != '0);

   // Record storage; contents need no reset since count gates reads.
   always_ff @(posedge clk_i) begin
      if (w_push_1) r_mem_1[r_wp_1] <= rec_1_i;
      if (w_push_2) r_mem_2[r_wp_2] <= rec_2_i;
   end

   // Per-core pointers and occupancy; a pair load pops both heads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wp_1  <= '0;
         r_rp_1  <= '0;
         r_cnt_1 <= '0;
         r_wp_2  <= '0;
         r_rp_2  <= '0;
         r_cnt_2 <= '0;
      end else begin
         if (w_push_1) r_wp_1 <= r_wp_1 + 1'b1;
         if (w_push_2) r_wp_2 <= r_wp_2 + 1'b1;
         if (w_load) begin
            r_rp_1 <= r_rp_1 + 1'b1;
            r_rp_2 <= r_rp_2 + 1'b1;
         end
         if (w_push_1 && !w_load) r_cnt_1 <= r_cnt_1 + CW'(1);
         else if (!w_push_1 && w_load) r_cnt_1 <= r_cnt_1 - CW'(1);
         if (w_push_2 && !w_load) r_cnt_2 <= r_cnt_2 + CW'(1);
         else if (!w_push_2 && w_load) r_cnt_2 <= r_cnt_2 - CW'(1);
      end
   end

   // Output pair register, handshake counter and sticky overflow.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pv     <= 1'b0;
         r_prec_1 <= '0;
         r_prec_2 <= '0;
         r_pcnt   <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_load) begin
            r_pv     <= 1'b1;
            r_prec_1 <= r_mem_1[r_rp_1];
            r_prec_2 <= r_mem_2[r_rp_2];
         end else if (w_hs) begin
            r_pv <= 1'b0;
         end
         if (w_hs) r_pcnt <= r_pcnt + 32'd1;
         if ((retire_1_i && !w_push_1) || (retire_2_i && !w_push_2))
            r_ovf <= 1'b1;
      end
   end

   // One-sided occupancy timer; saturates and latches desync.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_to     <= '0;
         r_desync <= 1'b0;
      end else if (w_one_sided) begin
         if (r_to != TW'(TIMEOUT)) begin
            r_to <= r_to + TW'(1);
            if (r_to == TW'(TIMEOUT - 1)) r_desync <= 1'b1;
         end
      end else begin
         r_to <= '0;
      end
   end

   assign stall_1_o    = r_cnt_1 >= CW'(DEPTH - SLACK);
   assign stall_2_o    = r_cnt_2 >= CW'(DEPTH - SLACK);
   assign pair_valid_o = r_pv;
   assign pair_rec_1_o = r_prec_1;
   assign pair_rec_2_o = r_prec_2;
   assign pair_count_o = r_pcnt;
   assign overflow_o   = r_ovf;
   assign desync_o     = r_desync;

endmodule
